dec_issue_ctrl: RTL
===================

Name: dec_issue_ctrl

Overview:
- Issue controller in front of the two-line decoder pair of the dual-issue core.
- Buffers fetched instruction pairs in a small in-order queue and presents up to two instructions per cycle on line0/line1.
- Handles partial acceptance by rename, and serializes branches and illegal instructions.
- On an illegal instruction it halts issue until the backend flushes.

Parameters:
- XLEN, 32, instruction/PC width (from package riscv)
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- fetch_valid_i  in  2  lane valid mask; legal values 00, 01, 11 (10 illegal, treated as 00)
- fetch_instr0_i  in  XLEN  lane0 instruction
- fetch_pc0_i  in  XLEN  lane0 PC
- fetch_instr1_i  in  XLEN  lane1 instruction
- fetch_pc1_i  in  XLEN  lane1 PC
- fetch_ready_o  out  1  queue can take a full pair this cycle
- line0_valid_o  out  1  line0 offered to decode/rename
- line0_instr_o  out  XLEN  line0 instruction
- line0_pc_o  out  XLEN  line0 PC
- line1_valid_o  out  1  line1 offered
- line1_instr_o  out  XLEN  line1 instruction
- line1_pc_o  out  XLEN  line1 PC
- line0_illegal_i  in  1  decoder0 verdict on line0_instr_o (combinational feedback)
- line1_illegal_i  in  1  decoder1 verdict on line1_instr_o
- line0_is_branch_i  in  1  decoder0 branch flag
- ren_ready_i  in  2  slots rename accepts this cycle: 0, 1 or 2; value 3 treated as 2
- flush_i  in  1  pipeline flush (mispredict/exception)
- halted_o  out  1  controller in HALT state
- count_o  out  $clog2(DEPTH)+1  queue occupancy

Behaviour:
- Clock and reset: one clock clk. Reset resetn is asynchronous and active-low.
- Reset values: queue empty, rd/wr pointers 0, state RUN.
  - count_o = 0, halted_o = 0, line*_valid_o = 0, line*_instr_o/pc_o = 0.
  - fetch_ready_o = 1, since it is derived from count.
- Storage: circular queue of {instr, pc} entries, registered.
- Outputs are combinational from the head entries. Data outputs are forced to 0 whenever the matching valid is 0.
- fetch_ready_o = (DEPTH - count >= 2) and not HALT. It depends on registered state only and never on fetch_valid_i.
- Push: when fetch_ready_o=1, write lane0 at wr_ptr; if lane1 is valid, write it at wr_ptr+1. wr_ptr advances by the number of valid lanes, modulo DEPTH.
- Offer rules in RUN:
  - line0_valid_o = count >= 1.
  - line1_valid_o = count >= 2, and not line0_illegal_i, and not line1_illegal_i, and not line0_is_branch_i.
  - An illegal line1 instruction is therefore delayed and re-offered on line0 in a later cycle.
  - At most one branch per issued pair.
- Issue count n = min(offered lines, ren_ready_i):
  - ren_ready_i=0 -> n=0.
  - ren_ready_i=1 -> only line0 is accepted.
- Pop: rd_ptr += n; count += pushed - n in the same cycle. Simultaneous push and pop are allowed, including at count = DEPTH-2.
- State machine:
  - RUN -> HALT when line0 is accepted (n >= 1) with line0_illegal_i=1.
  - HALT: line*_valid_o = 0, fetch_ready_o = 0, halted_o = 1; queue contents are held.
  - HALT -> RUN only on flush_i.
- Flush: flush_i has priority over every other event in that cycle. Next cycle: count 0, pointers 0, state RUN, and the same-cycle push is discarded. Outputs are not gated combinationally by flush_i; rename ignores offers in the flush cycle.
- Wrap-around: pointers wrap modulo DEPTH. A pair may straddle the wrap (e.g. wr_ptr=3 writes entries 3 and 0).
- Invariants: count never exceeds DEPTH and never underflows. Order is strictly FIFO and no instruction is duplicated.
- Assertions: no push when fetch_ready_o=0; fetch_valid_i never 10.

Decomposition:
- Package riscv holds: XLEN; FRONTEND_WIDTH (=2, the number of lines); typedef issue_entry_t {instr, pc}; enum issue_state_e {RUN, HALT}.
- One natural sub-module: dec_issue_queue. It is a 2-write/2-read circular buffer with push count and pop count, and holds pointers and count.
- The state machine and offer/serialization logic stay in dec_issue_ctrl.

Test Plan:
- After reset, push pair A(pc 0x100), B(0x104); ren_ready_i=2, no flags -> next cycle both lines valid with A/B; following cycle count_o=0 and both valids 0.
- Push A,B with ren_ready_i=1 for two cycles -> cycle 1 issues A on line0; cycle 2 B is on line0 (pc 0x104) and line1_valid_o=0; count goes 2 -> 1 -> 0.
- Head pair with line0_is_branch_i=1 and ren_ready_i=2 -> only the branch is issued. Next cycle the second instruction is on line0; the branch PC is never on line1.
- line0_illegal_i=1 and accepted -> halted_o=1 and fetch_ready_o=0 the next cycle; the remaining entry is held. After flush_i for 1 cycle: count_o=0, halted_o=0, fetch_ready_o=1.
- Fill to DEPTH=4 with ren_ready_i=0 -> fetch_ready_o=0 at count 3 and 4. Then ren_ready_i=2 with a simultaneous push of 2 at count 2 -> count stays 2 and the wrapped pair is issued in order.
- Assert resetn mid-stream (count 3) -> all outputs return to their reset values asynchronously; after release, the first fetched pair is issued normally.

Source files
------------

// File: rtl/dec_issue_ctrl_pkg.sv
// Shared types for the decode issue front end: entry layout, lane count and controller states.
package riscv;
  localparam int XLEN           = 32;
  localparam int FRONTEND_WIDTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } issue_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } issue_state_e;
endpackage

// File: rtl/dec_issue_ctrl_if.sv
// Fetch, decode-line, rename and flush signals between the front end and the issue controller.
interface dec_issue_if #(
  parameter int DEPTH = 4
);
  import riscv::*;

  logic [1:0]              fetch_valid_i;
  logic [XLEN-1:0]         fetch_instr0_i;
  logic [XLEN-1:0]         fetch_pc0_i;
  logic [XLEN-1:0]         fetch_instr1_i;
  logic [XLEN-1:0]         fetch_pc1_i;
  logic                    fetch_ready_o;
  logic                    line0_valid_o;
  logic [XLEN-1:0]         line0_instr_o;
  logic [XLEN-1:0]         line0_pc_o;
  logic                    line1_valid_o;
  logic [XLEN-1:0]         line1_instr_o;
  logic [XLEN-1:0]         line1_pc_o;
  logic                    line0_illegal_i;
  logic                    line1_illegal_i;
  logic                    line0_is_branch_i;
  logic [1:0]              ren_ready_i;
  logic                    flush_i;
  logic                    halted_o;
  logic [$clog2(DEPTH):0]  count_o;

  modport master (
    output fetch_valid_i, fetch_instr0_i, fetch_pc0_i, fetch_instr1_i, fetch_pc1_i,
    output line0_illegal_i, line1_illegal_i, line0_is_branch_i, ren_ready_i, flush_i,
    input  fetch_ready_o, line0_valid_o, line0_instr_o, line0_pc_o,
    input  line1_valid_o, line1_instr_o, line1_pc_o, halted_o, count_o
  );

  modport slave (
    input  fetch_valid_i, fetch_instr0_i, fetch_pc0_i, fetch_instr1_i, fetch_pc1_i,
    input  line0_illegal_i, line1_illegal_i, line0_is_branch_i, ren_ready_i, flush_i,
    output fetch_ready_o, line0_valid_o, line0_instr_o, line0_pc_o,
    output line1_valid_o, line1_instr_o, line1_pc_o, halted_o, count_o
  );
endinterface

// File: rtl/dec_issue_queue.sv
// Two-write / two-read circular buffer; reads expose the two oldest entries combinationally.
module dec_issue_queue
  import riscv::*;
#(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic [1:0]   push_cnt,
  input  issue_entry_t wdata [FRONTEND_WIDTH],
  input  logic [1:0]   pop_cnt,
  output issue_entry_t rdata [FRONTEND_WIDTH],
  output logic [CW-1:0] count
);
  issue_entry_t  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Payload storage needs no reset: validity is tracked by count alone.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FRONTEND_WIDTH; i++) begin
      if (push_cnt > 2'(i)) mem_reg[wr_ptr_reg + PW'(i)] <= wdata[i];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_cnt);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_cnt);
      count_reg  <= count_reg + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  for (genvar gi = 0; gi < FRONTEND_WIDTH; gi++) begin : g_rd
    assign rdata[gi] = mem_reg[rd_ptr_reg + PW'(gi)];
  end

  assign count = count_reg;
endmodule

// File: rtl/dec_issue_ctrl.sv
// Issue controller: offers up to two queued instructions per cycle, serializes branches/illegals, halts on illegal.
module dec_issue_ctrl
  import riscv::*;
#(
  parameter int DEPTH = 4
) (
  input logic       clk,
  input logic       resetn,
  dec_issue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  issue_state_e  state_reg;
  logic          halted_reg;
  logic [CW-1:0] count;
  issue_entry_t  head [FRONTEND_WIDTH];
  issue_entry_t  wdata [FRONTEND_WIDTH];
  logic          run;
  logic          fetch_ready;
  logic          lane0_v;
  logic          lane1_v;
  logic [1:0]    push_cnt;
  logic [1:0]    ren_eff;
  logic [1:0]    n_issue;
  logic          line0_valid;
  logic          line1_valid;

  assign run         = (state_reg == RUN);
  assign fetch_ready = run && (count <= CW'(DEPTH - 2));

  // A 10 lane mask is meaningless and is dropped like 00.
  assign lane0_v  = bus.fetch_valid_i[0];
  assign lane1_v  = (bus.fetch_valid_i == 2'b11);
  assign push_cnt = (!fetch_ready || bus.flush_i) ? 2'd0 :
                    lane1_v ? 2'd2 : lane0_v ? 2'd1 : 2'd0;

  assign wdata[0] = '{instr: bus.fetch_instr0_i, pc: bus.fetch_pc0_i};
  assign wdata[1] = '{instr: bus.fetch_instr1_i, pc: bus.fetch_pc1_i};

  dec_issue_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (bus.flush_i),
    .push_cnt (push_cnt),
    .wdata    (wdata),
    .pop_cnt  (n_issue),
    .rdata    (head),
    .count    (count)
  );

  // Line1 is withheld behind a branch or when either line is illegal, so line0 stays the only faulting slot.
  assign line0_valid = run && (count != '0);
  assign line1_valid = run && (count >= CW'(2)) && !bus.line0_illegal_i &&
                       !bus.line1_illegal_i && !bus.line0_is_branch_i;

  assign ren_eff = (bus.ren_ready_i == 2'd3) ? 2'd2 : bus.ren_ready_i;

  always_comb begin
    n_issue = 2'd0;
    if (line0_valid && ren_eff != 2'd0) n_issue = (line1_valid && ren_eff == 2'd2) ? 2'd2 : 2'd1;
    if (bus.flush_i) n_issue = 2'd0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg  <= RUN;
      halted_reg <= 1'b0;
    end else if (bus.flush_i) begin
      state_reg  <= RUN;
      halted_reg <= 1'b0;
    end else if (run && n_issue != 2'd0 && bus.line0_illegal_i) begin
      state_reg  <= HALT;
      halted_reg <= 1'b1;
    end
  end

  assign bus.fetch_ready_o = fetch_ready;
  assign bus.line0_valid_o = line0_valid;
  assign bus.line0_instr_o = line0_valid ? head[0].instr : '0;
  assign bus.line0_pc_o    = line0_valid ? head[0].pc    : '0;
  assign bus.line1_valid_o = line1_valid;
  assign bus.line1_instr_o = line1_valid ? head[1].instr : '0;
  assign bus.line1_pc_o    = line1_valid ? head[1].pc    : '0;
  assign bus.halted_o      = halted_reg;
  assign bus.count_o       = count;

  a_no_push_when_busy: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.fetch_valid_i != 2'b00 && !fetch_ready));
  a_no_lane_mask_10: assert property (@(posedge clk) disable iff (!resetn)
    bus.fetch_valid_i != 2'b10);
endmodule
